// File: rtl/pixel_dispatcher_pkg.sv
// Shared types for the pixel dispatcher: coordinate type, FSM states, scan-order codes.
package pixel_dispatcher_pkg;

    localparam int PIXEL_DATA_WIDTH = 10;

    typedef logic [PIXEL_DATA_WIDTH-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } disp_state_t;

    localparam logic SCAN_RASTER    = 1'b0;
    localparam logic SCAN_INTERLACE = 1'b1;

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Round-robin one-hot arbiter; grant is combinational from req, pointer moves only on advance.
// Priority starts one past the last granted requester; no backpressure of its own.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q;
    logic [PW-1:0] last_d;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the ring once starting after last_q; the wrap is explicit so N need not be a power of two.
    always_comb begin
        grant  = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = (last_q == PW'(N - 1)) ? '0 : last_q + PW'(1);
        for (int i = 0; i < N; i++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                last_d     = idx;
                found      = 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
        end
    end

    // Reset to N-1 so engine 0 has first priority after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PW'(N - 1);
        end else if (advance) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands out frame pixels one per cycle to free, requesting engines (round-robin); grant latency 1 cycle.
// Backpressure: an engine stays ineligible from its grant until its eng_done; frame ends after all retire.
module pixel_dispatcher #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int NUM_ENGINES      = 30,
    localparam int CNT_W           = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     scan_mode,
    input  logic [NUM_ENGINES-1:0]                   eng_req,
    input  logic [NUM_ENGINES-1:0]                   eng_done,
    output logic [NUM_ENGINES-1:0]                   eng_valid,
    output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_x,
    output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0]  eng_y,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic [CNT_W-1:0]                         issued_cnt
);

    import pixel_dispatcher_pkg::*;

    localparam int PDW  = PIXEL_DATA_WIDTH;
    localparam int N    = NUM_ENGINES;
    localparam int YW   = PDW + 1;
    localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;

    disp_state_t    state_q;
    disp_state_t    state_d;
    logic [N-1:0]   busy_mask;
    logic [N-1:0]   elig;
    logic [N-1:0]   grant;
    logic [PDW-1:0] cur_x;
    logic [PDW-1:0] cur_y;
    logic [PDW-1:0] nxt_x;
    logic [PDW-1:0] nxt_y;
    logic [YW-1:0]  y_inc;
    logic           scan_q;
    logic           jumped_q;
    logic           nxt_jumped;
    logic           do_grant;
    logic           last_pix;
    logic           frame_start;

    assign elig        = (state_q == ISSUE) ? (eng_req & ~busy_mask) : '0;
    assign do_grant    = |grant;
    assign frame_start = (state_q == IDLE) && start;
    assign last_pix    = (issued_cnt == CNT_W'(NPIX - 1));

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (elig),
        .advance(do_grant),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (do_grant && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (busy_mask == '0) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Interlaced order steps by two rows and falls back to row 1 exactly once per frame.
    always_comb begin
        nxt_x      = cur_x + PDW'(1);
        nxt_y      = cur_y;
        nxt_jumped = jumped_q;
        y_inc      = {1'b0, cur_y} + ((scan_q == SCAN_INTERLACE) ? YW'(2) : YW'(1));
        if (cur_x == PDW'(SCREEN_WIDTH - 1)) begin
            nxt_x = '0;
            if ((scan_q == SCAN_INTERLACE) && !jumped_q && (y_inc >= YW'(SCREEN_HEIGHT))) begin
                nxt_y      = PDW'(1);
                nxt_jumped = 1'b1;
            end else begin
                nxt_y = y_inc[PDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_mask  <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            scan_q     <= SCAN_RASTER;
            jumped_q   <= 1'b0;
            issued_cnt <= '0;
            eng_valid  <= '0;
        end else begin
            state_q   <= state_d;
            eng_valid <= grant;
            busy_mask <= (busy_mask & ~eng_done) | grant;
            if (frame_start) begin
                scan_q     <= scan_mode;
                cur_x      <= '0;
                cur_y      <= '0;
                jumped_q   <= 1'b0;
                issued_cnt <= '0;
            end else if (do_grant) begin
                cur_x      <= nxt_x;
                cur_y      <= nxt_y;
                jumped_q   <= nxt_jumped;
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
        end
    end

    // Each engine keeps its coordinates until it is granted again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_x <= '0;
            eng_y <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    eng_x[i*PDW +: PDW] <= cur_x;
                    eng_y[i*PDW +: PDW] <= cur_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher (W=4, H=3, N=2, PDW=4) with a cycle-level reference model.
module tb_pixel_dispatcher;

    localparam int PDW  = 4;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int N    = 2;
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(NPIX + 1);

    typedef struct {
        bit           scan;
        logic [N-1:0] req;
        int           lat;
        int           g0;
        int           g1;
        int           lx;
        int           ly;
        int           gap;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             scan_mode = 1'b0;
    logic [N-1:0]     eng_req = '0;
    logic [N-1:0]     eng_done = '0;
    logic [N-1:0]     eng_valid;
    logic [N*PDW-1:0] eng_x;
    logic [N*PDW-1:0] eng_y;
    logic             busy;
    logic             frame_done;
    logic [CW-1:0]    issued_cnt;

    always #5 clk = ~clk;

    pixel_dispatcher #(
        .PIXEL_DATA_WIDTH(PDW),
        .SCREEN_WIDTH    (W),
        .SCREEN_HEIGHT   (H),
        .NUM_ENGINES     (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .scan_mode (scan_mode),
        .eng_req   (eng_req),
        .eng_done  (eng_done),
        .eng_valid (eng_valid),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .busy      (busy),
        .frame_done(frame_done),
        .issued_cnt(issued_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected pixel order, frame phase, engine occupancy.
    int           px[NPIX];
    int           py[NPIX];
    bit           m_idle = 1'b1, m_issue = 1'b0, m_drain = 1'b0, m_done = 1'b0;
    bit           n_idle, n_issue, n_drain, n_done, fin;
    logic [N-1:0] m_mask = '0;
    int           m_cnt = 0;
    int           m_last = N - 1;
    int           hx[N];
    int           hy[N];
    int           pick;
    int           cyc = 0;

    // Engine behaviour knobs and per-frame statistics.
    logic [N-1:0] req_cfg = '0;
    int           lat_cfg = 2;
    bit           req_rnd = 1'b0, lat_rnd = 1'b0, hold_done = 1'b0, inject1 = 1'b0;
    int           rcnt[N];
    bit           park[N];
    int           gcount[N];
    int           last_gx, last_gy, fd_count, last_gcyc, min_gap, max_gap;

    logic [N-1:0] req_p, done_p, exp_v, elig, nd;
    bit           start_p;

    task automatic build(input bit s);
        int k;
        k = 0;
        if (!s) begin
            for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) begin px[k] = x; py[k] = y; k++; end
        end else begin
            for (int y = 0; y < H; y += 2) for (int x = 0; x < W; x++) begin px[k] = x; py[k] = y; k++; end
            for (int y = 1; y < H; y += 2) for (int x = 0; x < W; x++) begin px[k] = x; py[k] = y; k++; end
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        req_p   = eng_req;
        done_p  = eng_done;
        start_p = start;
        if (!reset) begin
            m_idle = 1'b1; m_issue = 1'b0; m_drain = 1'b0; m_done = 1'b0;
            m_mask = '0; m_cnt = 0; m_last = N - 1;
            for (int k = 0; k < N; k++) begin hx[k] = 0; hy[k] = 0; rcnt[k] = 0; park[k] = 1'b0; end
            eng_done = '0;
        end else begin
            exp_v = '0;
            if (m_issue) begin
                elig = req_p & ~m_mask;
                for (int k = 1; k <= N; k++) begin
                    pick = (m_last + k) % N;
                    if (exp_v == '0 && elig[pick]) exp_v[pick] = 1'b1;
                end
            end
            chk("grant_vector", eng_valid, exp_v);
            for (int k = 0; k < N; k++) begin
                if (exp_v[k] && m_cnt < NPIX) begin
                    hx[k] = px[m_cnt];
                    hy[k] = py[m_cnt];
                    gcount[k]++;
                    last_gx = hx[k];
                    last_gy = hy[k];
                    if (last_gcyc >= 0) begin
                        if (cyc - last_gcyc < min_gap) min_gap = cyc - last_gcyc;
                        if (cyc - last_gcyc > max_gap) max_gap = cyc - last_gcyc;
                    end
                    last_gcyc = cyc;
                    m_last = k;
                    m_cnt++;
                end
            end
            for (int k = 0; k < N; k++) begin
                chk("eng_x", eng_x[k*PDW +: PDW], hx[k]);
                chk("eng_y", eng_y[k*PDW +: PDW], hy[k]);
            end
            fin     = (exp_v != '0) && (m_cnt == NPIX);
            n_done  = m_drain && (m_mask == '0);
            n_drain = (m_drain && (m_mask != '0)) || (m_issue && fin);
            n_issue = (m_issue && !fin) || (m_idle && start_p);
            n_idle  = (m_idle && !start_p) || m_done;
            if (m_idle && start_p) begin
                m_cnt = 0;
                build(scan_mode);
            end
            m_mask  = (m_mask & ~done_p) | exp_v;
            m_idle  = n_idle; m_issue = n_issue; m_drain = n_drain; m_done = n_done;
            chk("busy", busy, m_issue || m_drain);
            chk("frame_done", frame_done, m_done);
            chk("issued_cnt", issued_cnt, m_cnt);
            if (frame_done) fd_count++;

            nd = '0;
            for (int k = 0; k < N; k++) begin
                if (eng_valid[k]) begin
                    rcnt[k] = lat_rnd ? int'($urandom_range(1, 4)) : lat_cfg;
                    park[k] = hold_done;
                end
                if (rcnt[k] > 0 && !(park[k] && hold_done && rcnt[k] == 1)) begin
                    rcnt[k]--;
                    if (rcnt[k] == 0) nd[k] = 1'b1;
                end
            end
            if (inject1 && !m_mask[1] && rcnt[1] == 0) nd[1] = 1'b1;
            eng_done = nd;
            eng_req  = req_rnd ? N'($urandom) : req_cfg;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) gcount[k] = 0;
        fd_count  = 0;
        last_gcyc = -1;
        min_gap   = 1000;
        max_gap   = 0;
    endtask

    task automatic pulse_start(input bit s);
        scan_mode = s;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int t;
        t = 0;
        while (fd_count == 0 && t < 3000) begin step(1); t++; end
        chk({name, "_timeout"}, fd_count > 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, eng_valid, 0);
        chk({tag, "_x"}, eng_x, 0);
        chk({tag, "_y"}, eng_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_cnt"}, issued_cnt, 0);
    endtask

    vec_t tbl[4];
    int   t;

    initial begin
        tbl[0] = '{scan: 1'b0, req: 2'b11, lat: 2, g0: 6,  g1: 6,  lx: 3, ly: 2, gap: 0};
        tbl[1] = '{scan: 1'b1, req: 2'b11, lat: 2, g0: 6,  g1: 6,  lx: 3, ly: 1, gap: 0};
        tbl[2] = '{scan: 1'b0, req: 2'b01, lat: 5, g0: 12, g1: 0,  lx: 3, ly: 2, gap: 6};
        tbl[3] = '{scan: 1'b1, req: 2'b10, lat: 1, g0: 0,  g1: 12, lx: 3, ly: 1, gap: 2};

        #1 reset = 1'b0;
        step(2);
        chk_zero("reset");
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 4; i++) begin
            req_cfg = tbl[i].req;
            lat_cfg = tbl[i].lat;
            step(1);
            clear_stats();
            pulse_start(tbl[i].scan);
            wait_frame("vec");
            step(3);
            chk("vec_grants_e0", gcount[0], tbl[i].g0);
            chk("vec_grants_e1", gcount[1], tbl[i].g1);
            chk("vec_last_x", last_gx, tbl[i].lx);
            chk("vec_last_y", last_gy, tbl[i].ly);
            chk("vec_issued", issued_cnt, NPIX);
            chk("vec_fdone_count", fd_count, 1);
            if (tbl[i].gap != 0) begin
                chk("vec_min_gap", min_gap, tbl[i].gap);
                chk("vec_max_gap", max_gap, tbl[i].gap);
            end
        end

        // start while busy and in DONE, plus stray done on an idle engine
        req_cfg = 2'b01;
        lat_cfg = 3;
        clear_stats();
        pulse_start(1'b0);
        t = 0;
        while (m_cnt < 3 && t < 200) begin step(1); t++; end
        chk("ign_reach3", m_cnt >= 3, 1);
        pulse_start(1'b1);
        inject1 = 1'b1;
        step(4);
        inject1 = 1'b0;
        wait_frame("ign");
        pulse_start(1'b0);
        step(4);
        chk("ign_issued", issued_cnt, NPIX);
        chk("ign_busy", busy, 0);
        chk("ign_e1", gcount[1], 0);
        chk("ign_fdone_count", fd_count, 1);
        chk("ign_last_y", last_gy, 2);

        // reset in the middle of a frame
        req_cfg = 2'b11;
        lat_cfg = 3;
        clear_stats();
        pulse_start(1'b0);
        t = 0;
        while (m_cnt < 5 && t < 200) begin step(1); t++; end
        chk("rst_reach5", m_cnt, 5);
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        step(2);
        reset = 1'b1;
        step(2);
        chk("rst_no_fdone", fd_count, 0);
        lat_cfg = 2;
        clear_stats();
        pulse_start(1'b0);
        wait_frame("after_rst");
        step(2);
        chk("after_rst_total", gcount[0] + gcount[1], NPIX);
        chk("after_rst_fdone", fd_count, 1);

        // dones of the final grants held back: DRAIN persists until they arrive
        clear_stats();
        pulse_start(1'b1);
        t = 0;
        while (m_cnt < NPIX - N && t < 300) begin step(1); t++; end
        hold_done = 1'b1;
        t = 0;
        while (m_cnt < NPIX && t < 300) begin step(1); t++; end
        chk("drain_all_issued", m_cnt, NPIX);
        step(4);
        chk("drain_busy", busy, 1);
        chk("drain_no_fdone", fd_count, 0);
        hold_done = 1'b0;
        t = 0;
        while (fd_count == 0 && t < 50) begin step(1); t++; end
        chk("drain_release_to_fdone", t, 3);
        step(2);

        // randomized request levels, done latencies and scan order
        req_rnd = 1'b1;
        lat_rnd = 1'b1;
        for (int f = 0; f < 6; f++) begin
            clear_stats();
            pulse_start(1'($urandom_range(0, 1)));
            wait_frame("rnd");
            step(2);
            chk("rnd_issued", issued_cnt, NPIX);
            chk("rnd_total", gcount[0] + gcount[1], NPIX);
            chk("rnd_fdone_count", fd_count, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
